multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_pkg.sv | 38 +++
 rtl/opcode_class.sv | 24 ++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, opcode classes,
// ALU operation selects and write-back source selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIalu   = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] ClsR      = 3'd0;
  localparam logic [2:0] ClsIalu   = 3'd1;
  localparam logic [2:0] ClsLoad   = 3'd2;
  localparam logic [2:0] ClsStore  = 3'd3;
  localparam logic [2:0] ClsBranch = 3'd4;
  localparam logic [2:0] ClsJal    = 3'd5;
  localparam logic [2:0] ClsNone   = 3'd7;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluRtype = 2'b10;
  localparam logic [1:0] AluItype = 2'b11;

  localparam logic [1:0] WbAlu = 2'b00;
  localparam logic [1:0] WbMem = 2'b01;
  localparam logic [1:0] WbPc4 = 2'b10;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: maps a 7-bit opcode to a class code and a legal bit.
module opcode_class
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] cls,
  output logic       legal
);

  always_comb begin
    cls   = ClsNone;
    legal = 1'b1;
    case (opcode)
      OpR:      cls = ClsR;
      OpIalu:   cls = ClsIalu;
      OpLoad:   cls = ClsLoad;
      OpStore:  cls = ClsStore;
      OpBranch: cls = ClsBranch;
      OpJal:    cls = ClsJal;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a sticky TRAP state
// for illegal opcodes.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned USE_MEM_READY = 1,
  parameter int unsigned ALUOP_W       = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               branch,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic               reg_write,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         wb_sel,
  output logic               instr_done,
  output logic               illegal,
  output logic [2:0]         state
);

  state_e     state_q, state_d;
  logic [6:0] opcode_q;
  logic       rst_q;
  logic [6:0] cls_opcode;
  logic [2:0] cls;
  logic       legal;
  logic       mem_ok;
  logic [1:0] alu_op2;

  // Single classifier: sees the live opcode while decoding, the latched one afterwards.
  assign cls_opcode = (state_q == StDecode) ? opcode : opcode_q;
  assign mem_ok     = (USE_MEM_READY == 0) || mem_ready;

  opcode_class u_opcode_class (
    .opcode(cls_opcode),
    .cls   (cls),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      opcode_q <= '0;
      rst_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      rst_q   <= 1'b0;
      if (state_q == StDecode) opcode_q <= opcode;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op2    = AluAdd;
    wb_sel     = WbAlu;
    instr_done = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read = 1'b1;
        // The first cycle after reset keeps fetching without committing pc/ir.
        if (mem_ok && !rst_q) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: state_d = legal ? StExec : StTrap;
      StExec: begin
        case (cls)
          ClsR: begin
            alu_op2 = AluRtype;
            state_d = StWb;
          end
          ClsIalu: begin
            alu_src = 1'b1;
            alu_op2 = AluItype;
            state_d = StWb;
          end
          ClsLoad, ClsStore: begin
            alu_src = 1'b1;
            state_d = StMem;
          end
          ClsBranch: begin
            alu_op2    = AluSub;
            branch     = 1'b1;
            pc_write   = zero;
            instr_done = 1'b1;
            state_d    = StFetch;
          end
          ClsJal: begin
            pc_write = 1'b1;
            state_d  = StWb;
          end
          default: state_d = StTrap;
        endcase
      end
      StMem: begin
        if (cls == ClsLoad) begin
          mem_read = 1'b1;
          if (mem_ok) state_d = StWb;
        end else begin
          mem_write = 1'b1;
          if (mem_ok) begin
            instr_done = 1'b1;
            state_d    = StFetch;
          end
        end
      end
      StWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
        if (cls == ClsLoad) begin
          wb_sel     = WbMem;
          mem_to_reg = 1'b1;
        end else if (cls == ClsJal) begin
          wb_sel = WbPc4;
        end
      end
      StTrap:  illegal = 1'b1;
      default: state_d = StFetch;
    endcase

    // Quiet every strobe while reset is asserted, whatever state is being abandoned.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      branch     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      reg_write  = 1'b0;
      alu_op2    = AluAdd;
      wb_sel     = WbAlu;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign alu_op = ALUOP_W'(alu_op2);
  assign state  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle stimulus and expected outputs are queued,
// then replayed and compared one cycle at a time.
module tb_multicycle_control;
  import ctrl_pkg::*;

  // Strobe vectors, order {pc_write, ir_write, branch, mem_read, mem_write, mem_to_reg,
  // alu_src, reg_write}.
  localparam logic [7:0] SbNone  = 8'b0000_0000;
  localparam logic [7:0] SbMr    = 8'b0001_0000;
  localparam logic [7:0] SbFetch = 8'b1101_0000;
  localparam logic [7:0] SbAsrc  = 8'b0000_0010;
  localparam logic [7:0] SbBr    = 8'b0010_0000;
  localparam logic [7:0] SbBrPc  = 8'b1010_0000;
  localparam logic [7:0] SbPc    = 8'b1000_0000;
  localparam logic [7:0] SbMw    = 8'b0000_1000;
  localparam logic [7:0] SbRw    = 8'b0000_0001;
  localparam logic [7:0] SbWbLd  = 8'b0000_0101;

  localparam logic [6:0] CR  = 7'b0110011;
  localparam logic [6:0] CI  = 7'b0010011;
  localparam logic [6:0] CLd = 7'b0000011;
  localparam logic [6:0] CSt = 7'b0100011;
  localparam logic [6:0] CBr = 7'b1100011;
  localparam logic [6:0] CJ  = 7'b1101111;
  localparam logic [6:0] CX  = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [6:0] opcode = 7'd0;

  logic       pc_write, ir_write, branch, mem_read, mem_write, mem_to_reg, alu_src, reg_write;
  logic [1:0] alu_op, wb_sel;
  logic       instr_done, illegal;
  logic [2:0] state;

  logic       pc_write1, ir_write1, branch1, mem_read1, mem_write1, mem_to_reg1, alu_src1;
  logic       reg_write1, instr_done1, illegal1;
  logic [2:0] alu_op1;
  logic [1:0] wb_sel1;
  logic [2:0] state1;

  logic [16:0] obs;
  logic [8:0]  obs1;
  logic [9:0]  stim_q[$];
  logic [16:0] exp_q[$];
  logic [8:0]  exp1_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .branch    (branch),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_to_reg(mem_to_reg),
    .alu_src   (alu_src),
    .reg_write (reg_write),
    .alu_op    (alu_op),
    .wb_sel    (wb_sel),
    .instr_done(instr_done),
    .illegal   (illegal),
    .state     (state)
  );

  multicycle_control #(
    .USE_MEM_READY(0),
    .ALUOP_W      (3)
  ) u_dut_noready (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (1'b0),
    .pc_write  (pc_write1),
    .ir_write  (ir_write1),
    .branch    (branch1),
    .mem_read  (mem_read1),
    .mem_write (mem_write1),
    .mem_to_reg(mem_to_reg1),
    .alu_src   (alu_src1),
    .reg_write (reg_write1),
    .alu_op    (alu_op1),
    .wb_sel    (wb_sel1),
    .instr_done(instr_done1),
    .illegal   (illegal1),
    .state     (state1)
  );

  assign obs  = {state, pc_write, ir_write, branch, mem_read, mem_write, mem_to_reg, alu_src,
                 reg_write, alu_op, wb_sel, instr_done, illegal};
  assign obs1 = {state1, mem_write1, instr_done1, pc_write1, alu_op1};

  function automatic logic [16:0] ev(input logic [2:0] st, input logic [7:0] sb,
                                     input logic [1:0] aop, input logic [1:0] wb,
                                     input logic done, input logic ill);
    return {st, sb, aop, wb, done, ill};
  endfunction

  task automatic plan(input logic rst, input logic rdy, input logic z, input logic [6:0] opc,
                      input logic [16:0] e);
    stim_q.push_back({rst, rdy, z, opc});
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [16:0] e;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b1; opcode = CR;
    plan(1, 1, 0, CR, ev(StFetch, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StFetch, SbMr, 2'b00, 2'b00, 0, 0));
    while (exp_q.size() != 0) begin
      @(negedge clk);
      {reset, mem_ready, zero, opcode} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset: got %h want %h", obs, e);
      end
    end
  endtask

  task automatic test_alu_ops();
    logic [16:0] e;
    // R-type, with opcode/mem_ready/zero noise outside DECODE
    plan(0, 1, 0, CR, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 0, 1, CR, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 1, CX, ev(StExec, SbNone, 2'b10, 2'b00, 0, 0));
    plan(0, 0, 0, CX, ev(StWb, SbRw, 2'b00, 2'b00, 1, 0));
    // I-ALU back to back
    plan(0, 1, 0, CX, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CI, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 0, 0, CLd, ev(StExec, SbAsrc, 2'b11, 2'b00, 0, 0));
    plan(0, 1, 0, CJ, ev(StWb, SbRw, 2'b00, 2'b00, 1, 0));
    // JAL
    plan(0, 1, 0, CR, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CJ, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StExec, SbPc, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CLd, ev(StWb, SbRw, 2'b00, 2'b10, 1, 0));
    while (exp_q.size() != 0) begin
      @(negedge clk);
      {reset, mem_ready, zero, opcode} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL alu_ops: got %h want %h", obs, e);
      end
    end
  endtask

  task automatic test_load_stall();
    logic [16:0] e;
    plan(0, 1, 0, CLd, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CLd, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StExec, SbAsrc, 2'b00, 2'b00, 0, 0));
    for (int i = 0; i < 3; i++) plan(0, 0, 0, CR, ev(StMem, SbMr, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StMem, SbMr, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StWb, SbWbLd, 2'b00, 2'b01, 1, 0));
    while (exp_q.size() != 0) begin
      @(negedge clk);
      {reset, mem_ready, zero, opcode} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL load_stall: got %h want %h", obs, e);
      end
    end
  endtask

  task automatic test_branch();
    logic [16:0] e;
    plan(0, 1, 0, CBr, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CBr, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 1, CR, ev(StExec, SbBrPc, 2'b01, 2'b00, 1, 0));
    plan(0, 1, 1, CBr, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 1, CBr, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StExec, SbBr, 2'b01, 2'b00, 1, 0));
    plan(0, 0, 0, CR, ev(StFetch, SbMr, 2'b00, 2'b00, 0, 0));
    while (exp_q.size() != 0) begin
      @(negedge clk);
      {reset, mem_ready, zero, opcode} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL branch: got %h want %h", obs, e);
      end
    end
  endtask

  task automatic test_store_reset();
    logic [16:0] e;
    plan(0, 1, 0, CSt, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 0, 0, CSt, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StExec, SbAsrc, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StMem, SbMw, 2'b00, 2'b00, 1, 0));
    plan(0, 1, 0, CSt, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CSt, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 0, 0, CR, ev(StExec, SbAsrc, 2'b00, 2'b00, 0, 0));
    plan(0, 0, 0, CR, ev(StMem, SbMw, 2'b00, 2'b00, 0, 0));
    plan(1, 0, 0, CR, ev(StMem, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StFetch, SbMr, 2'b00, 2'b00, 0, 0));
    while (exp_q.size() != 0) begin
      @(negedge clk);
      {reset, mem_ready, zero, opcode} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL store_reset: got %h want %h", obs, e);
      end
    end
  endtask

  task automatic test_trap();
    logic [16:0] e;
    plan(0, 1, 0, CX, ev(StFetch, SbFetch, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CX, ev(StDecode, SbNone, 2'b00, 2'b00, 0, 0));
    for (int i = 0; i < 10; i++)
      plan(0, i[0], i[1], CR, ev(StTrap, SbNone, 2'b00, 2'b00, 0, 1));
    plan(1, 1, 0, CR, ev(StTrap, SbNone, 2'b00, 2'b00, 0, 0));
    plan(0, 1, 0, CR, ev(StFetch, SbMr, 2'b00, 2'b00, 0, 0));
    while (exp_q.size() != 0) begin
      @(negedge clk);
      {reset, mem_ready, zero, opcode} = stim_q.pop_front();
      #1;
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL trap: got %h want %h", obs, e);
      end
    end
  endtask

  task automatic test_no_ready();
    logic [8:0] e;
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; opcode = CSt;
    // Expected {state, mem_write, instr_done, pc_write, alu_op[2:0]}
    exp1_q.push_back({StFetch, 1'b0, 1'b0, 1'b0, 3'b000});
    exp1_q.push_back({StFetch, 1'b0, 1'b0, 1'b1, 3'b000});
    exp1_q.push_back({StDecode, 1'b0, 1'b0, 1'b0, 3'b000});
    exp1_q.push_back({StExec, 1'b0, 1'b0, 1'b0, 3'b000});
    exp1_q.push_back({StMem, 1'b1, 1'b1, 1'b0, 3'b000});
    exp1_q.push_back({StFetch, 1'b0, 1'b0, 1'b1, 3'b000});
    while (exp1_q.size() != 0) begin
      @(negedge clk);
      reset = 1'b0;
      #1;
      e = exp1_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        errors++;
        $display("FAIL no_ready: got %h want %h", obs1, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_stall();
    test_branch();
    test_store_reset();
    test_trap();
    test_no_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
